// File: rtl/uart_pkg.sv
// uart_pkg: state type and derived frame/baud constants shared by the UART transmit controller.
package uart_pkg;
  typedef enum logic {IDLE, SEND} state_e;
  function automatic int frame_bits(input int stop_bits);
    return 9 + stop_bits;
  endfunction
  function automatic int baud_div(input int clkfreq, input int baud);
    return clkfreq / baud;
  endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: pulses tick once every BAUD_DIV enabled cycles; clr restarts the count at 0.
module uart_baud_gen #(
  parameter int BAUD_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int W = $clog2(BAUD_DIV);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    tick = en && cnt_q == W'(BAUD_DIV - 1);
    cnt_d = (clr || tick) ? '0 : en ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/uart_xmit_ctrl.sv
// uart_xmit_ctrl: sequences the 10-bit UART transmit shift register through one frame per valid/ready handshake.
module uart_xmit_ctrl
  import uart_pkg::*;
#(
  parameter int CLKFREQ   = 100_000_000,
  parameter int BAUD      = 9600,
  parameter int STOP_BITS = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic valid,
  output logic ready,
  output logic sh_idle,
  output logic sh_ld,
  output logic sh_en,
  output logic busy
);
  localparam int BAUD_DIV   = baud_div(CLKFREQ, BAUD);
  localparam int FRAME_BITS = frame_bits(STOP_BITS);
  if (BAUD_DIV < 2) begin : g_bad_div
    $error("uart_xmit_ctrl: CLKFREQ/BAUD must be at least 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_xmit_ctrl: STOP_BITS must be 1 or 2");
  end
  state_e state_q, state_d;
  logic [3:0] bit_q, bit_d;
  logic tick, last;
  // Holding the divider in clear while idle makes every frame start at count 0.
  uart_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .clk (clk),
    .rst (rst),
    .clr (state_q == IDLE),
    .en  (state_q == SEND),
    .tick(tick)
  );
  always_comb begin
    last = bit_q == 4'(FRAME_BITS - 1);
    state_d = state_q == IDLE ? (valid ? SEND : IDLE) : (tick && last ? IDLE : SEND);
    bit_d = state_q == IDLE ? '0 : (tick && !last) ? bit_q + 4'd1 : bit_q;
    ready = !rst && state_q == IDLE;
    busy = !rst && state_q == SEND;
    sh_ld = ready && valid;
    sh_idle = ready && !valid;
    sh_en = busy && tick && !last;
  end
  always_ff @(posedge clk) begin
    state_q <= rst ? IDLE : state_d;
    bit_q <= rst ? '0 : bit_d;
  end
endmodule

// File: tb/tb_uart_xmit_ctrl.sv
// tb_uart_xmit_ctrl: table vectors plus a timed-event scoreboard for the UART transmit controller.
module tb_uart_xmit_ctrl;
  localparam int DIV = 10;
  localparam int FB = 10;
  localparam int NOLIM = 1 << 30;
  logic clk = 0, rst = 1, valid = 0, rst2 = 1, valid2 = 0;
  logic ready, sh_idle, sh_ld, sh_en, busy;
  logic ready2, sh_idle2, sh_ld2, sh_en2, busy2;
  logic [7:0] data = 0;
  logic [9:0] sr;
  int cyc = 0, pass = 0, total = 0;
  typedef struct {int c; logic v;} line_t;
  typedef struct {int c; logic r; logic b;} rb_t;
  typedef struct {logic rst; logic valid; logic [4:0] exp;} vec_t;
  int q_ld[$], q_en[$];
  line_t q_line[$];
  rb_t q_rb[$];
  vec_t vec[6];

  always #5 clk = ~clk;

  uart_xmit_ctrl #(.CLKFREQ(100), .BAUD(10), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .valid(valid), .ready(ready),
    .sh_idle(sh_idle), .sh_ld(sh_ld), .sh_en(sh_en), .busy(busy)
  );
  uart_xmit_ctrl #(.CLKFREQ(100), .BAUD(10), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst2), .valid(valid2), .ready(ready2),
    .sh_idle(sh_idle2), .sh_ld(sh_ld2), .sh_en(sh_en2), .busy(busy2)
  );

  // Model of the external shift register; the line is its LSB.
  always @(posedge clk)
    sr <= rst ? '0 : sh_idle ? '1 : sh_ld ? {1'b1, data, 1'b0} : sh_en ? {1'b1, sr[9:1]} : sr;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s at cycle %0d: got %0h, want %0h", n, cyc, act, exp);
  endtask

  task automatic push_frame(input int t, input logic [7:0] d, input int lim);
    logic [9:0] f;
    f = {1'b1, d, 1'b0};
    if (t < lim) q_ld.push_back(t);
    for (int k = 1; k < FB; k++) if (t + k * DIV < lim) q_en.push_back(t + k * DIV);
    for (int k = 0; k < FB; k++) if (t + 6 + k * DIV < lim) q_line.push_back('{t + 6 + k * DIV, f[k]});
    if (t + 1 + FB * DIV < lim) q_line.push_back('{t + 1 + FB * DIV, 1'b1});
    if (t + 1 < lim) q_rb.push_back('{t + 1, 1'b0, 1'b1});
    if (t + FB * DIV < lim) q_rb.push_back('{t + FB * DIV, 1'b0, 1'b1});
    if (t + 1 + FB * DIV < lim) q_rb.push_back('{t + 1 + FB * DIV, 1'b1, 1'b0});
  endtask

  task automatic monitor();
    if (q_ld.size() != 0 && q_ld[0] == cyc) begin
      chk("sh_ld", sh_ld, 1);
      void'(q_ld.pop_front());
    end else if (sh_ld) chk("sh_ld_unexpected", sh_ld, 0);
    if (q_en.size() != 0 && q_en[0] == cyc) begin
      chk("sh_en", sh_en, 1);
      void'(q_en.pop_front());
    end else if (sh_en) chk("sh_en_unexpected", sh_en, 0);
    if (q_line.size() != 0 && q_line[0].c == cyc) begin
      chk("line_bit", sr[0], q_line[0].v);
      void'(q_line.pop_front());
    end
    if (q_rb.size() != 0 && q_rb[0].c == cyc) begin
      chk("ready_busy", {ready, busy}, {q_rb[0].r, q_rb[0].b});
      void'(q_rb.pop_front());
    end
  endtask

  task automatic sample();
    @(negedge clk);
    monitor();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step();
    sample();
    adv();
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  initial begin
    int t, n, r_at;
    vec[0] = '{1'b1, 1'b0, 5'b00000};
    vec[1] = '{1'b1, 1'b1, 5'b00000};
    vec[2] = '{1'b0, 1'b0, 5'b11000};
    vec[3] = '{1'b0, 1'b1, 5'b10100};
    vec[4] = '{1'b1, 1'b1, 5'b00000};
    vec[5] = '{1'b0, 1'b0, 5'b11000};
    adv();
    for (int i = 0; i < 6; i++) begin
      rst = vec[i].rst;
      valid = vec[i].valid;
      if (!rst && valid) q_ld.push_back(cyc);
      sample();
      chk($sformatf("vec%0d", i), {ready, sh_idle, sh_ld, sh_en, busy}, vec[i].exp);
      adv();
    end
    rst2 = 0;
    valid = 0;
    for (int i = 0; i < 50; i++) begin
      sample();
      chk("idle_outputs", {ready, sh_idle, busy}, 3'b110);
      adv();
    end
    data = 8'hA5;
    valid = 1;
    t = cyc;
    push_frame(t, data, NOLIM);
    step();
    valid = 0;
    run_to(t + 105);
    data = 8'h5A;
    valid = 1;
    t = cyc;
    for (int f = 0; f < 3; f++) push_frame(t + f * (FB * DIV + 1), data, NOLIM);
    run_to(t + 2 * (FB * DIV + 1) + 1);
    valid = 0;
    run_to(t + 3 * (FB * DIV + 1) + 3);
    data = 8'h96;
    valid = 1;
    t = cyc;
    push_frame(t, data, t + 45);
    step();
    valid = 0;
    run_to(t + 45);
    rst = 1;
    sample();
    chk("outputs_in_reset", {ready, sh_idle, sh_ld, sh_en, busy}, 5'b00000);
    adv();
    rst = 0;
    sample();
    chk("idle_after_reset", {ready, sh_idle, busy}, 3'b110);
    adv();
    data = 8'h3C;
    valid = 1;
    t = cyc;
    push_frame(t, data, NOLIM);
    step();
    valid = 0;
    run_to(t + 105);
    data = 8'hC3;
    valid = 1;
    t = cyc;
    push_frame(t, data, NOLIM);
    step();
    while (cyc < t + 105) begin
      valid = (cyc < t + 95) ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
    end
    valid2 = 1;
    t = cyc;
    n = 0;
    r_at = -1;
    for (int i = 0; i < 116; i++) begin
      sample();
      if (i == 0) chk("stop2_sh_ld", sh_ld2, 1);
      if (sh_en2) n++;
      if (i > 0 && ready2 && r_at < 0) r_at = cyc;
      adv();
      valid2 = 0;
    end
    chk("stop2_ready_cycle", r_at, t + 111);
    chk("stop2_sh_en_count", n, 10);
    chk("scoreboard_drained", q_ld.size() + q_en.size() + q_line.size() + q_rb.size(), 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
